vga_tile_vram: RTL and testbench
================================

Name: vga_tile_vram

Overview:
- Parametrised successor of the fixed 640x480 tile display. Single-clock (clk is the pixel clock) video timing generator, tile-map VRAM and scroll viewport.
- Timing, tile size, map size and pixel format are parameters. Scroll offsets are double-buffered and applied only at frame boundaries.
- Adds CPU read-back of VRAM, out-of-range write rejection, a frame-start pulse and a frame counter.
- Sits between the CPU data bus (data_* handshake) and the display PHY/DVI encoder.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, active level of vga_hs/vga_vs
- TILE_SHIFT, 4, log2 tile edge in pixels
- MAP_W_BITS, 6, log2 tile-map width in tiles
- MAP_H_BITS, 6, log2 tile-map height in tiles
- OUT_BITS, 8, bits per output colour channel (>=3)

Ports:
- clk  in  1  pixel/system clock
- reset  in  1  asynchronous, active-low reset
- data_length  out  32  VRAM depth = 2^(MAP_W_BITS+MAP_H_BITS), constant
- data_address  in  32  signed CPU tile address
- data_din  in  8  RGB332 tile colour
- data_dout  out  8  read-back data
- data_we  in  1  write strobe
- data_oe  in  1  read strobe
- offset_h  in  32  signed horizontal scroll in pixels
- offset_v  in  32  signed vertical scroll in pixels
- frame_start  out  1  one-cycle pulse at the start of vertical blank
- frame_count  out  16  frames completed, wraps
- vga_hs  out  1  hsync
- vga_vs  out  1  vsync
- vga_de  out  1  data enable
- vga_r  out  OUT_BITS  red
- vga_g  out  OUT_BITS  green
- vga_b  out  OUT_BITS  blue

Behaviour:
- Reset (reset=0, async), all registers clear:
  - count_h, count_v, shadow offsets, frame_count = 0
  - vga_de, vga_r/g/b, data_dout, frame_start = 0
  - vga_hs/vga_vs = inactive (~SYNC_POL)
  - VRAM contents are not cleared.
- Counters:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - count_h wraps at H_TOTAL-1; count_v advances on count_h wrap and wraps at V_TOTAL-1.
- Sync and DE:
  - hs asserted for count_h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs likewise on count_v.
  - de = count_h<H_ACTIVE && count_v<V_ACTIVE.
- Pipeline, total latency 2 cycles:
  - stage 1 registers viewport x = count_h + shadow_h and y = count_v + shadow_v, each truncated to MAP_*_BITS+TILE_SHIFT bits, so the map wraps toroidally.
  - stage 2 reads VRAM at {y[top:TILE_SHIFT], x[top:TILE_SHIFT]}.
  - hs/vs/de are delayed 2 cycles to stay aligned with pixel data.
- Colour:
  - Each RGB332 channel is expanded to OUT_BITS by bit replication (e.g. r=3'b101 -> 8'hB6; b=2'b11 -> 8'hFF).
  - Channels are 0 whenever delayed de=0.
- Scroll double buffering:
  - offset_h/offset_v are captured into shadow registers only in the cycle with count_h==H_TOTAL-1 && count_v==V_ACTIVE-1.
  - Mid-frame changes have no visible effect until the next frame.
  - Negative offsets wrap modulo the map size.
- frame_start:
  - One-cycle high in the cycle after the shadow capture.
  - frame_count increments in that same cycle and wraps 0xFFFF -> 0.
- CPU writes:
  - data_we=1 with 0 <= data_address < data_length writes data_din; visible from the next frame scan.
  - Negative or >= data_length addresses are ignored, with no aliasing.
- CPU reads:
  - data_oe=1 loads data_dout with VRAM[data_address] the next cycle.
  - data_dout holds its value when data_oe=0.
  - An out-of-range read returns 0.
- Simultaneous we and oe, same address: read-first, so data_dout gets the old data.
- The video read port is independent of the CPU port; there are no CPU stalls.

Decomposition:
- Package vga_tile_pkg holds:
  - derived localparams H_TOTAL, V_TOTAL, sync start/end, MAP_ADDR_BITS
  - rgb332 channel expansion functions
- Natural sub-module vga_timing_gen: counters, hs/vs/de and the frame-boundary strobe.
- VRAM is a same-clock true dual-port RAM instance: port A for the CPU (read-first), port B for video read.

Test Plan:
- Reset released, defaults, run 2 frames -> hs low 96 clks every 800; vs low 2 lines every 525; de high 640x480 per frame; frame_count=2; frame_start pulses twice, 420000 clks apart.
- Write addr 0 = 8'hE0, addr 1 = 8'h03, offsets 0 -> pixels x0..15 line 0 show r=FF,g=0,b=0; x16..31 show b=FF; each visible exactly 2 clks after the matching de.
- offset_h changed 0->16 mid-frame (line 100) -> current frame unchanged; next frame x0 shows the addr-1 colour.
- offset_h=-16 -> x0 line 0 shows tile (row 0, col 63) via wrap.
- Write addr 4096 and addr -1 with 8'hFF -> no VRAM change (scan and read-back unchanged); read addr 4096 returns 0.
- Same-cycle we+oe on addr 5 (old 8'h12, new 8'h34) -> data_dout=8'h12 next cycle; following read returns 8'h34. Reset asserted mid-line -> outputs reach reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/vga_tile_pkg.sv
// Shared types and helpers for the parametrised tile-map VGA display.
// Geometry is derived here so timing and datapath agree on widths.
package vga_tile_pkg;

    localparam int PIX_BITS = 8;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    function automatic int line_total(input int act, input int fp,
                                      input int sw, input int bp);
        return act + fp + sw + bp;
    endfunction

    function automatic int sync_start(input int act, input int fp);
        return act + fp;
    endfunction

    function automatic int sync_end(input int act, input int fp,
                                    input int sw);
        return act + fp + sw;
    endfunction

    function automatic int map_addr_bits(input int wb, input int hb);
        return wb + hb;
    endfunction

    // Bit i (LSB = 0) of an nb-bit channel replicated MSB-first to ob bits.
    function automatic logic rep_bit(input logic [2:0] v, input int nb,
                                     input int ob, input int i);
        return v[nb - 1 - ((ob - 1 - i) % nb)];
    endfunction

endpackage

// File: rtl/vga_tile_dpram.sv
// Same-clock true dual-port tile RAM: port A read-first CPU access,
// port B read-only video fetch. Contents are never reset.
module vga_tile_dpram #(
    parameter int AW = 12,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          en_a,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] din_a,
    output logic [DW-1:0] dout_a,
    input  logic [AW-1:0] addr_b,
    output logic [DW-1:0] dout_b
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (en_a) begin
            dout_a <= mem[addr_a];
            if (we_a) mem[addr_a] <= din_a;
        end
        dout_b <= mem[addr_b];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters, raw sync/DE, the scroll-capture strobe and the
// frame-start pulse / frame counter.
module vga_timing_gen
    import vga_tile_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int HW      = $clog2(H_TOTAL + 1),
    localparam int VW      = $clog2(V_TOTAL + 1)
) (
    input  logic          clk,
    input  logic          reset,
    output logic [HW-1:0] count_h,
    output logic [VW-1:0] count_v,
    output sync_t         sync,
    output logic          cap,
    output logic          frame_start,
    output logic [15:0]   frame_count
);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_B   = HW'(sync_start(H_ACTIVE, H_FP));
    localparam logic [HW-1:0] HS_E   = HW'(sync_end(H_ACTIVE, H_FP, H_SYNC));
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_LACT = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_B   = VW'(sync_start(V_ACTIVE, V_FP));
    localparam logic [VW-1:0] VS_E   = VW'(sync_end(V_ACTIVE, V_FP, V_SYNC));

    logic h_end;
    logic in_hs;
    logic in_vs;

    assign h_end = (count_h == H_LAST);
    assign cap   = h_end && (count_v == V_LACT);
    assign in_hs = (count_h >= HS_B) && (count_h < HS_E);
    assign in_vs = (count_v >= VS_B) && (count_v < VS_E);

    assign sync.hs = in_hs ? SYNC_POL : ~SYNC_POL;
    assign sync.vs = in_vs ? SYNC_POL : ~SYNC_POL;
    assign sync.de = (count_h < H_ACT) && (count_v < V_ACT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_h <= '0;
            count_v <= '0;
        end else if (h_end) begin
            count_h <= '0;
            count_v <= (count_v == V_LAST) ? '0 : count_v + 1'b1;
        end else begin
            count_h <= count_h + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_start <= cap;
            if (cap) frame_count <= frame_count + 16'd1;
        end
    end

endmodule

// File: rtl/vga_tile_vram.sv
// Tile-map VGA display: timing, double-buffered toroidal scroll, two-stage
// video fetch and a non-stalling CPU port with range-checked access.
module vga_tile_vram
    import vga_tile_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int TILE_SHIFT = 4,
    parameter int MAP_W_BITS = 6,
    parameter int MAP_H_BITS = 6,
    parameter int OUT_BITS   = 8
) (
    input  logic                clk,
    input  logic                reset,
    output logic [31:0]         data_length,
    input  logic [31:0]         data_address,
    input  logic [PIX_BITS-1:0] data_din,
    output logic [PIX_BITS-1:0] data_dout,
    input  logic                data_we,
    input  logic                data_oe,
    input  logic [31:0]         offset_h,
    input  logic [31:0]         offset_v,
    output logic                frame_start,
    output logic [15:0]         frame_count,
    output logic                vga_hs,
    output logic                vga_vs,
    output logic                vga_de,
    output logic [OUT_BITS-1:0] vga_r,
    output logic [OUT_BITS-1:0] vga_g,
    output logic [OUT_BITS-1:0] vga_b
);

    localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);
    localparam int AB = map_addr_bits(MAP_W_BITS, MAP_H_BITS);
    localparam int XB = MAP_W_BITS + TILE_SHIFT;
    localparam int YB = MAP_H_BITS + TILE_SHIFT;
    localparam sync_t SYNC_IDLE = '{hs: ~SYNC_POL, vs: ~SYNC_POL, de: 1'b0};

    logic [HW-1:0]       count_h;
    logic [VW-1:0]       count_v;
    sync_t               sync_raw;
    sync_t               s1;
    sync_t               s2;
    logic                cap;
    logic [XB-1:0]       shadow_h;
    logic [YB-1:0]       shadow_v;
    logic [XB-1:0]       x1;
    logic [YB-1:0]       y1;
    logic [AB-1:0]       addr_b;
    logic [PIX_BITS-1:0] pix;
    logic [PIX_BITS-1:0] ram_a;
    logic                in_range;
    logic                rd_q;
    logic                ok_q;
    logic [PIX_BITS-1:0] hold_q;
    logic [OUT_BITS-1:0] red;
    logic [OUT_BITS-1:0] grn;
    logic [OUT_BITS-1:0] blu;
    logic                unused_bits;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_timing (
        .clk         (clk),
        .reset       (reset),
        .count_h     (count_h),
        .count_v     (count_v),
        .sync        (sync_raw),
        .cap         (cap),
        .frame_start (frame_start),
        .frame_count (frame_count)
    );

    assign data_length = 32'd1 << AB;
    // Upper bits zero means both non-negative and below the map depth.
    assign in_range    = ~|data_address[31:AB];
    assign unused_bits = ^{offset_h[31:XB], offset_v[31:YB]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_h <= '0;
            shadow_v <= '0;
            x1       <= '0;
            y1       <= '0;
            s1       <= SYNC_IDLE;
            s2       <= SYNC_IDLE;
        end else begin
            if (cap) begin
                shadow_h <= offset_h[XB-1:0];
                shadow_v <= offset_v[YB-1:0];
            end
            x1 <= XB'(count_h) + shadow_h;
            y1 <= YB'(count_v) + shadow_v;
            s1 <= sync_raw;
            s2 <= s1;
        end
    end

    assign addr_b = {y1[YB-1:TILE_SHIFT], x1[XB-1:TILE_SHIFT]};

    vga_tile_dpram #(
        .AW (AB),
        .DW (PIX_BITS)
    ) u_vram (
        .clk    (clk),
        .en_a   ((data_we | data_oe) & in_range),
        .we_a   (data_we & in_range),
        .addr_a (data_address[AB-1:0]),
        .din_a  (data_din),
        .dout_a (ram_a),
        .addr_b (addr_b),
        .dout_b (pix)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q   <= 1'b0;
            ok_q   <= 1'b0;
            hold_q <= '0;
        end else begin
            rd_q   <= data_oe;
            ok_q   <= in_range;
            hold_q <= data_dout;
        end
    end

    assign data_dout = rd_q ? (ok_q ? ram_a : '0) : hold_q;

    for (genvar i = 0; i < OUT_BITS; i++) begin : g_exp
        assign red[i] = rep_bit(pix[7:5], 3, OUT_BITS, i);
        assign grn[i] = rep_bit(pix[4:2], 3, OUT_BITS, i);
        assign blu[i] = rep_bit({1'b0, pix[1:0]}, 2, OUT_BITS, i);
    end

    assign vga_hs = s2.hs;
    assign vga_vs = s2.vs;
    assign vga_de = s2.de;
    assign vga_r  = s2.de ? red : '0;
    assign vga_g  = s2.de ? grn : '0;
    assign vga_b  = s2.de ? blu : '0;

endmodule

// File: tb/tb_vga_tile_vram.sv
// Directed bench for vga_tile_vram on a shrunken 48x22 raster
// (32x16 visible) with the default 64x64 map of 16-pixel tiles.
module tb_vga_tile_vram;

    localparam int HT = 48;
    localparam int FT = 48 * 22;
    localparam int FS_CNT = 15 * 48 + 48;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] data_length;
    logic [31:0] data_address = '0;
    logic [7:0]  data_din = '0;
    logic [7:0]  data_dout;
    logic        data_we = 1'b0;
    logic        data_oe = 1'b0;
    logic [31:0] offset_h = '0;
    logic [31:0] offset_v = '0;
    logic        frame_start;
    logic [15:0] frame_count;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_de;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    vga_tile_vram #(
        .H_ACTIVE (32), .H_FP (4), .H_SYNC (8), .H_BP (4),
        .V_ACTIVE (16), .V_FP (2), .V_SYNC (2), .V_BP (2),
        .SYNC_POL (1'b0), .TILE_SHIFT (4),
        .MAP_W_BITS (6), .MAP_H_BITS (6), .OUT_BITS (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_length  (data_length),
        .data_address (data_address),
        .data_din     (data_din),
        .data_dout    (data_dout),
        .data_we      (data_we),
        .data_oe      (data_oe),
        .offset_h     (offset_h),
        .offset_v     (offset_v),
        .frame_start  (frame_start),
        .frame_count  (frame_count),
        .vga_hs       (vga_hs),
        .vga_vs       (vga_vs),
        .vga_de       (vga_de),
        .vga_r        (vga_r),
        .vga_g        (vga_g),
        .vga_b        (vga_b)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fs();
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (frame_start !== 1'b1 && i < 2 * FT);
        total++;
        if (frame_start !== 1'b1) begin
            bad++;
            $display("FAIL wait_fs timeout got=%b need=1", frame_start);
        end
    endtask

    // Leaves outputs showing raster position c of the next frame.
    task automatic goto_cnt(input int c);
        wait_fs();
        step(FT - FS_CNT + c + 2);
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [7:0] d);
        data_address = a;
        data_din = d;
        data_we = 1'b1;
        @(negedge clk);
        data_we = 1'b0;
    endtask

    task automatic cpu_read(input logic [31:0] a);
        data_address = a;
        data_oe = 1'b1;
        @(negedge clk);
        data_oe = 1'b0;
    endtask

    task automatic test_reset();
        step(3);
        total++;
        if ({vga_hs, vga_vs, vga_de} !== 3'b110) begin
            bad++;
            $display("FAIL rst_sync got=%b need=110", {vga_hs, vga_vs, vga_de});
        end
        total++;
        if ({vga_r, vga_g, vga_b} !== 24'h0) begin
            bad++;
            $display("FAIL rst_rgb got=%h need=000000", {vga_r, vga_g, vga_b});
        end
        total++;
        if ({data_dout, frame_count, frame_start} !== 25'h0) begin
            bad++;
            $display("FAIL rst_regs got=%h/%h/%b need=0", data_dout,
                     frame_count, frame_start);
        end
        total++;
        if (data_length !== 32'd4096) begin
            bad++;
            $display("FAIL length got=%0d need=4096", data_length);
        end
        reset = 1'b1;
    endtask

    task automatic test_frames();
        int hs_low = 0;
        int vs_low = 0;
        int de_cnt = 0;
        int fs_n = 0;
        int fs1 = 0;
        int fs2 = 0;
        logic de1 = 1'b0;
        logic de2 = 1'b0;
        for (int n = 1; n <= 2 * FT; n++) begin
            @(negedge clk);
            if (vga_hs === 1'b0) hs_low++;
            if (vga_vs === 1'b0) vs_low++;
            if (vga_de === 1'b1) de_cnt++;
            if (n == 1) de1 = vga_de;
            if (n == 2) de2 = vga_de;
            if (frame_start === 1'b1) begin
                fs_n++;
                if (fs_n == 1) fs1 = n;
                if (fs_n == 2) fs2 = n;
            end
        end
        total++;
        if (hs_low != 352) begin
            bad++;
            $display("FAIL hs_low got=%0d need=352", hs_low);
        end
        total++;
        if (vs_low != 192) begin
            bad++;
            $display("FAIL vs_low got=%0d need=192", vs_low);
        end
        total++;
        if (de_cnt != 1024) begin
            bad++;
            $display("FAIL de_cnt got=%0d need=1024", de_cnt);
        end
        total++;
        if ({de1, de2} !== 2'b01) begin
            bad++;
            $display("FAIL de_latency got=%b need=01", {de1, de2});
        end
        total++;
        if (fs_n != 2 || fs1 != FS_CNT || fs2 - fs1 != FT) begin
            bad++;
            $display("FAIL fs_pulses got=%0d@%0d,%0d need=2@%0d,%0d",
                     fs_n, fs1, fs2, FS_CNT, FS_CNT + FT);
        end
        total++;
        if (frame_count !== 16'd2) begin
            bad++;
            $display("FAIL frame_count got=%0d need=2", frame_count);
        end
    endtask

    task automatic test_pixels();
        logic [24:0] exp;
        cpu_write(32'd0, 8'hE0);
        cpu_write(32'd1, 8'h03);
        cpu_write(32'd63, 8'h1C);
        cpu_write(32'd4095, 8'h55);
        goto_cnt(-1);
        for (int x = -1; x <= 32; x++) begin
            if (x > -1) step(1);
            if (x < 0 || x > 31) exp = 25'h0;
            else if (x < 16) exp = {1'b1, 24'hFF0000};
            else exp = {1'b1, 24'h0000FF};
            total++;
            if ({vga_de, vga_r, vga_g, vga_b} !== exp) begin
                bad++;
                $display("FAIL pix x=%0d got=%h need=%h", x,
                         {vga_de, vga_r, vga_g, vga_b}, exp);
            end
        end
    endtask

    task automatic test_scroll_mid();
        goto_cnt(5 * HT);
        offset_h = 32'd16;
        step(3 * HT);
        total++;
        if ({vga_de, vga_r, vga_g, vga_b} !== {1'b1, 24'hFF0000}) begin
            bad++;
            $display("FAIL scroll_cur got=%h need=1ff0000",
                     {vga_de, vga_r, vga_g, vga_b});
        end
        goto_cnt(0);
        total++;
        if ({vga_de, vga_r, vga_g, vga_b} !== {1'b1, 24'h0000FF}) begin
            bad++;
            $display("FAIL scroll_next got=%h need=10000ff",
                     {vga_de, vga_r, vga_g, vga_b});
        end
    endtask

    task automatic test_wrap();
        offset_h = 32'hFFFF_FFF0;
        goto_cnt(0);
        total++;
        if ({vga_de, vga_r, vga_g, vga_b} !== {1'b1, 24'h00FF00}) begin
            bad++;
            $display("FAIL wrap_col63 got=%h need=100ff00",
                     {vga_de, vga_r, vga_g, vga_b});
        end
        step(16);
        total++;
        if ({vga_de, vga_r, vga_g, vga_b} !== {1'b1, 24'hFF0000}) begin
            bad++;
            $display("FAIL wrap_col0 got=%h need=1ff0000",
                     {vga_de, vga_r, vga_g, vga_b});
        end
        offset_h = 32'd0;
    endtask

    task automatic test_out_of_range();
        cpu_write(32'd4096, 8'hFF);
        cpu_write(32'hFFFF_FFFF, 8'hFF);
        cpu_read(32'd0);
        total++;
        if (data_dout !== 8'hE0) begin
            bad++;
            $display("FAIL oor_alias0 got=%h need=e0", data_dout);
        end
        cpu_read(32'd4095);
        total++;
        if (data_dout !== 8'h55) begin
            bad++;
            $display("FAIL oor_alias4095 got=%h need=55", data_dout);
        end
        step(2);
        total++;
        if (data_dout !== 8'h55) begin
            bad++;
            $display("FAIL dout_hold got=%h need=55", data_dout);
        end
        cpu_read(32'd4096);
        total++;
        if (data_dout !== 8'h00) begin
            bad++;
            $display("FAIL oor_read got=%h need=00", data_dout);
        end
        goto_cnt(0);
        total++;
        if ({vga_de, vga_r, vga_g, vga_b} !== {1'b1, 24'hFF0000}) begin
            bad++;
            $display("FAIL oor_scan got=%h need=1ff0000",
                     {vga_de, vga_r, vga_g, vga_b});
        end
    endtask

    task automatic test_back_to_back();
        cpu_write(32'd5, 8'h12);
        data_address = 32'd5;
        data_din = 8'h34;
        data_we = 1'b1;
        data_oe = 1'b1;
        @(negedge clk);
        data_we = 1'b0;
        data_oe = 1'b0;
        total++;
        if (data_dout !== 8'h12) begin
            bad++;
            $display("FAIL read_first got=%h need=12", data_dout);
        end
        cpu_read(32'd5);
        total++;
        if (data_dout !== 8'h34) begin
            bad++;
            $display("FAIL read_after got=%h need=34", data_dout);
        end
    endtask

    task automatic test_async_reset();
        goto_cnt(2 * HT + 5);
        total++;
        if (vga_de !== 1'b1 || frame_count == 16'd0) begin
            bad++;
            $display("FAIL pre_reset got=%b/%0d need=1/nonzero", vga_de,
                     frame_count);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b} !== {3'b110, 24'h0}) begin
            bad++;
            $display("FAIL async_video got=%h need=%h",
                     {vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b},
                     {3'b110, 24'h0});
        end
        total++;
        if ({data_dout, frame_count, frame_start} !== 25'h0) begin
            bad++;
            $display("FAIL async_regs got=%h/%h/%b need=0", data_dout,
                     frame_count, frame_start);
        end
        step(2);
        reset = 1'b1;
        step(2);
    endtask

    initial begin
        test_reset();
        test_frames();
        test_pixels();
        test_scroll_mid();
        test_wrap();
        test_out_of_range();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
